call_stack: RTL and testbench



---
 rtl/call_stack.sv | 96 +++++++++
 tb/tb_call_stack.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// rtl/call_stack.sv - return-address stack between the CALL/RET decoder and the PC load path
// Optional sticky overflow/underflow flags are enabled by defining CALL_STACK_ERR_EN.
module call_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_addr,
    output logic                       pc_load,
    output logic [WIDTH-1:0]           pc_target,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
`ifdef CALL_STACK_ERR_EN
    output logic                       full,
    output logic                       err_overflow,
    output logic                       err_underflow
`else
    output logic                       full
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] entry [DEPTH];
    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_dec;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wr_idx;
    logic             is_empty;
    logic             is_full;
    logic             do_pop;
    logic             do_replace;
    logic             do_push;
    logic             wr_en;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == CW'(DEPTH));
    assign sp_dec   = sp - CW'(1);
    assign top_idx  = sp_dec[PW-1:0];

    // A simultaneous push and pop on a non-empty stack overwrites the top in place.
    assign do_pop     = pop && !is_empty;
    assign do_replace = push && do_pop;
    assign do_push    = push && !do_pop && !is_full;
    assign wr_en      = rst && (do_replace || do_push);
    assign wr_idx     = do_replace ? top_idx : sp[PW-1:0];

    assign count = sp;
    assign empty = is_empty;
    assign full  = is_full;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry[wr_idx] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp        <= '0;
            pc_load   <= 1'b0;
            pc_target <= '0;
        end else begin
            pc_load <= do_pop;
            if (do_pop) begin
                pc_target <= entry[top_idx];
            end
            if (do_pop && !push) begin
                sp <= sp_dec;
            end else if (do_push) begin
                sp <= sp + CW'(1);
            end
        end
    end

`ifdef CALL_STACK_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (push && !pop && is_full) begin
                err_overflow <= 1'b1;
            end
            if (pop && is_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_call_stack.sv
// tb/tb_call_stack.sv - scoreboard bench for call_stack (default DEPTH=8, WIDTH=8)
// Error-flag checks are compiled in when CALL_STACK_ERR_EN is defined.
module tb_call_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] push_addr;
    logic       pc_load;
    logic [7:0] pc_target;
    logic [3:0] count;
    logic       empty;
    logic       full;
`ifdef CALL_STACK_ERR_EN
    logic       err_overflow;
    logic       err_underflow;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    call_stack #(.DEPTH(8), .WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .push_addr    (push_addr),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .count        (count),
        .empty        (empty),
`ifdef CALL_STACK_ERR_EN
        .full         (full),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
`else
        .full         (full)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pc_load pulse must match the oldest expected return address.
    initial begin
        forever begin
            @(negedge clk);
            if (pc_load === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pc_load", 32'(pc_target), 32'hFFFF_FFFF);
                end else begin
                    chk("pc_target_lifo", 32'(pc_target), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input logic p, input logic q, input logic [7:0] a);
        push      = p;
        pop       = q;
        push_addr = a;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] exp, input logic [3:0] exp_count);
        exp_q.push_back(exp);
        step(1'b0, 1'b1, 8'h00);
        chk("pop_pc_load", 32'(pc_load), 32'd1);
        chk("pop_count", 32'(count), 32'(exp_count));
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; push_addr = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_pc_load", 32'(pc_load), 32'd0);
        chk("reset_pc_target", 32'(pc_target), 32'd0);
        rst = 1'b1;

        // Basic LIFO
        step(1'b1, 1'b0, 8'h10);
        step(1'b1, 1'b0, 8'h14);
        step(1'b1, 1'b0, 8'h18);
        chk("basic_count", 32'(count), 32'd3);
        pop_expect(8'h18, 4'd2);
        pop_expect(8'h14, 4'd1);
        pop_expect(8'h10, 4'd0);
        step(1'b0, 1'b0, 8'h00);
        chk("basic_pc_load_low", 32'(pc_load), 32'd0);
        chk("basic_empty", 32'(empty), 32'd1);
        chk("basic_target_held", 32'(pc_target), 32'h10);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i * 4));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        step(1'b1, 1'b0, 8'h40);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_full", 32'(full), 32'd1);
`ifdef CALL_STACK_ERR_EN
        chk("ovf_flag", 32'(err_overflow), 32'd1);
`endif
        pop_expect(8'h1C, 4'd7);
        for (int i = 6; i >= 0; i--) pop_expect(8'(i * 4), 4'(i));
`ifdef CALL_STACK_ERR_EN
        chk("ovf_flag_sticky", 32'(err_overflow), 32'd1);
`endif

        // Push together with pop replaces the top
        step(1'b1, 1'b0, 8'h20);
        exp_q.push_back(8'h20);
        step(1'b1, 1'b1, 8'h30);
        chk("replace_pc_load", 32'(pc_load), 32'd1);
        chk("replace_count", 32'(count), 32'd1);
        pop_expect(8'h30, 4'd0);

        // Pop while empty
        step(1'b0, 1'b1, 8'h00);
        chk("udf_pc_load", 32'(pc_load), 32'd0);
        chk("udf_count", 32'(count), 32'd0);
        chk("udf_target_held", 32'(pc_target), 32'h30);
`ifdef CALL_STACK_ERR_EN
        chk("udf_flag", 32'(err_underflow), 32'd1);
`endif

        // Reset wins over a simultaneous pop
        step(1'b1, 1'b0, 8'h08);
        step(1'b1, 1'b0, 8'h08);
        rst = 1'b0;
        step(1'b0, 1'b1, 8'h00);
        rst = 1'b1;
        chk("rst_pop_count", 32'(count), 32'd0);
        chk("rst_pop_pc_load", 32'(pc_load), 32'd0);
        chk("rst_pop_target", 32'(pc_target), 32'd0);
`ifdef CALL_STACK_ERR_EN
        chk("rst_pop_ovf", 32'(err_overflow), 32'd0);
        chk("rst_pop_udf", 32'(err_underflow), 32'd0);
`endif

        // Alternating push/pop
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'(8'h80 + i * 4));
            chk("alt_push_count", 32'(count), 32'd1);
            pop_expect(8'(8'h80 + i * 4), 4'd0);
        end

        repeat (3) step(1'b0, 1'b0, 8'h00);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
